// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Types and constants shared by the instruction-fetch front-end.
//               fetch_entry_t is one queued fetch result {pc, inst}.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] INST_BYTES         = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK      = 32'hFFFF_FFFC;
    localparam logic [31:0] DEFAULT_START_ADDR = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_axi_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_axi_if
// Description : Bus bundle of the fetch front-end: redirect input, MMU
//               instruction read port and the decode valid/ready port.
//               master = fetch unit, slave = surrounding core / MMU / decode.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_axi_if;

    logic        FLUSH;
    logic [31:0] NEW_PC;
    logic        MEM_WAIT;
    logic        INST_RDEN;
    logic [31:0] INST_RADDR;
    logic        INST_RVALID;
    logic [31:0] INST_RDATA;
    logic        FETCH_VALID;
    logic [31:0] FETCH_PC;
    logic [31:0] FETCH_INST;
    logic        FETCH_READY;

    modport master (
        input  FLUSH, NEW_PC, MEM_WAIT, INST_RVALID, INST_RDATA, FETCH_READY,
        output INST_RDEN, INST_RADDR, FETCH_VALID, FETCH_PC, FETCH_INST
    );

    modport slave (
        output FLUSH, NEW_PC, MEM_WAIT, INST_RVALID, INST_RDATA, FETCH_READY,
        input  INST_RDEN, INST_RADDR, FETCH_VALID, FETCH_PC, FETCH_INST
    );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO of fetch_entry_t, FIFO_DEPTH entries.
//               Head is presented combinationally (zero added latency).
// Ports       : clk, rst (async, active-high), push/push_data, pop, clear,
//               count (occupancy), head (oldest entry)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  fetch_entry_t                  push_data,
    input  logic                          pop,
    input  logic                          clear,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output fetch_entry_t                  head
);

    localparam int AW = $clog2(FIFO_DEPTH);

    fetch_entry_t   r_mem [FIFO_DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= push_data;
            end
            if (clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
                if (pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign count = r_wr_ptr - r_rd_ptr;
    assign head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/inst_fetch_axi.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_axi
// Description : Instruction fetch front-end ahead of the AXI MMU. Generates
//               sequential PCs, issues one outstanding read at a time, queues
//               responses and hands {pc, inst} to decode. FLUSH redirects the
//               PC, clears the queue and discards any in-flight response.
// Ports       : CLK, RST (async, active-high), bus (inst_fetch_axi_if.master),
//               PERF_WAIT_CNT (only with INST_FETCH_PERF_CNT_EN)
// Options     : `define INST_FETCH_PERF_CNT_EN adds a saturating counter of
//               cycles spent with INST_RDEN && MEM_WAIT.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_axi
    import fetch_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] START_ADDR = DEFAULT_START_ADDR
) (
    input  logic                 CLK,
    input  logic                 RST,
    inst_fetch_axi_if.master     bus
`ifdef INST_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          PERF_WAIT_CNT
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]    r_pc;
    logic [31:0]    r_req_pc;
    logic           r_outstanding;
    logic           r_discard;

    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_used;
    fetch_entry_t   w_head;
    fetch_entry_t   w_push_data;
    logic           w_valid;
    logic           w_rden;
    logic           w_accept;
    logic           w_resp;
    logic           w_push;
    logic           w_pop;

    always_comb begin
        // Credits: queued entries plus the in-flight one must leave a slot.
        w_used   = w_count + CW'(r_outstanding);
        // Gating with RST keeps the request low while reset is held. A new
        // request is allowed with one outstanding only when its response is
        // arriving now, which also covers the discard case.
        w_rden   = !RST && !bus.FLUSH
                 && (w_used < CW'(FIFO_DEPTH))
                 && (!r_outstanding || bus.INST_RVALID);
        w_accept = w_rden && !bus.MEM_WAIT;
        w_resp   = bus.INST_RVALID && r_outstanding;
        w_push   = w_resp && !r_discard && !bus.FLUSH;
        w_valid  = (w_count != '0);
        w_pop    = w_valid && bus.FETCH_READY;
        w_push_data.pc   = r_req_pc;
        w_push_data.inst = bus.INST_RDATA;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc          <= START_ADDR;
            r_req_pc      <= START_ADDR;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
        end else if (bus.FLUSH) begin
            r_pc          <= bus.NEW_PC & PC_ALIGN_MASK;
            // A response landing in the flush cycle is simply dropped; one
            // still in flight must be swallowed when it returns.
            r_outstanding <= r_outstanding && !bus.INST_RVALID;
            r_discard     <= r_outstanding && !bus.INST_RVALID;
        end else begin
            if (w_accept) begin
                r_pc     <= r_pc + INST_BYTES;
                r_req_pc <= r_pc;
            end
            if (w_accept) begin
                r_outstanding <= 1'b1;
            end else if (w_resp) begin
                r_outstanding <= 1'b0;
            end
            if (w_resp) begin
                r_discard <= 1'b0;
            end
        end
    end

    fetch_queue #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk       (CLK),
        .rst       (RST),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .clear     (bus.FLUSH),
        .count     (w_count),
        .head      (w_head)
    );

    assign bus.INST_RDEN   = w_rden;
    assign bus.INST_RADDR  = r_pc;
    assign bus.FETCH_VALID = w_valid;
    assign bus.FETCH_PC    = w_head.pc;
    assign bus.FETCH_INST  = w_head.inst;

`ifdef INST_FETCH_PERF_CNT_EN
    logic [31:0] r_perf_wait_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_perf_wait_cnt <= '0;
        end else if (w_rden && bus.MEM_WAIT && (r_perf_wait_cnt != 32'hFFFF_FFFF)) begin
            r_perf_wait_cnt <= r_perf_wait_cnt + 32'd1;
        end
    end

    assign PERF_WAIT_CNT = r_perf_wait_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_axi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_axi
// Description : Self-checking bench for inst_fetch_axi. An MMU responder with
//               programmable latency feeds the DUT; a scoreboard expects the
//               decode stream to be consecutive word PCs from the last
//               redirect, each paired with the responder's data for that PC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_axi;
    import fetch_pkg::*;

    localparam int          FIFO_DEPTH = 4;
    localparam logic [31:0] START_ADDR = 32'h0000_0000;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    inst_fetch_axi_if bus ();
`ifdef INST_FETCH_PERF_CNT_EN
    logic [31:0] PERF_WAIT_CNT;
`endif

    inst_fetch_axi #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .START_ADDR (START_ADDR)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
`ifdef INST_FETCH_PERF_CNT_EN
        ,
        .PERF_WAIT_CNT (PERF_WAIT_CNT)
`endif
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_req;
    logic [31:0] exp_dec;
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_dly;
    int          lat_lo = 0;
    int          lat_hi = 0;
    int          n_acc = 0;
    int          n_pop = 0;
    bit          s_rden, s_acc, s_fv, s_pop;
    logic [31:0] s_raddr, s_fpc, s_finst;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic idle_inputs;
        bus.FLUSH       = 1'b0;
        bus.NEW_PC      = 32'h0;
        bus.MEM_WAIT    = 1'b0;
        bus.INST_RVALID = 1'b0;
        bus.INST_RDATA  = 32'h0;
        bus.FETCH_READY = 1'b0;
    endtask

    // Called at a falling edge; drives one cycle, samples, runs the
    // scoreboard and returns at the next falling edge.
    task automatic cycle(input bit flush, input logic [31:0] npc, input bit mw,
                         input bit rdy, input bit junk);
        bus.FLUSH       = flush;
        bus.NEW_PC      = npc;
        bus.MEM_WAIT    = mw;
        bus.FETCH_READY = rdy;
        if (pend && pend_dly == 0) begin
            bus.INST_RVALID = 1'b1;
            bus.INST_RDATA  = inst_of(pend_addr);
            pend = 1'b0;
        end else begin
            if (pend) pend_dly--;
            // Spurious responses only while nothing is outstanding.
            bus.INST_RVALID = junk && !pend;
            bus.INST_RDATA  = $urandom;
        end
        #1;
        s_rden  = bus.INST_RDEN;
        s_raddr = bus.INST_RADDR;
        s_fv    = bus.FETCH_VALID;
        s_fpc   = bus.FETCH_PC;
        s_finst = bus.FETCH_INST;
        s_acc   = s_rden && !mw;
        s_pop   = s_fv && rdy;
        if (flush) begin
            n_cmp++;
            if (s_rden !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_rden: got %b want 0", s_rden);
            end
        end
        if (s_acc) begin
            n_cmp++;
            if (s_raddr !== exp_req || pend) begin
                n_fail++;
                $display("FAIL req_addr: got %h (pending=%0d) want %h (pending=0)", s_raddr, pend, exp_req);
            end
            exp_req   = exp_req + 32'd4;
            pend      = 1'b1;
            pend_addr = s_raddr;
            pend_dly  = $urandom_range(lat_hi, lat_lo);
            n_acc++;
        end
        if (s_pop) begin
            n_cmp++;
            if (s_fpc !== exp_dec || s_finst !== inst_of(exp_dec)) begin
                n_fail++;
                $display("FAIL decode_entry: got pc=%h inst=%h want pc=%h inst=%h",
                         s_fpc, s_finst, exp_dec, inst_of(exp_dec));
            end
            exp_dec = exp_dec + 32'd4;
            n_pop++;
        end
        if (flush) begin
            exp_req = npc & 32'hFFFF_FFFC;
            exp_dec = npc & 32'hFFFF_FFFC;
        end
        @(negedge CLK);
    endtask

    task automatic apply_reset;
        RST = 1'b1;
        idle_inputs();
        pend    = 1'b0;
        exp_req = START_ADDR;
        exp_dec = START_ADDR;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        idle_inputs();
        pend    = 1'b0;
        exp_req = START_ADDR;
        exp_dec = START_ADDR;
        @(negedge CLK);
        n_cmp++;
        if (bus.INST_RDEN !== 1'b0 || bus.INST_RADDR !== START_ADDR) begin
            n_fail++;
            $display("FAIL reset_req: got rden=%b addr=%h want rden=0 addr=%h",
                     bus.INST_RDEN, bus.INST_RADDR, START_ADDR);
        end
        n_cmp++;
        if (bus.FETCH_VALID !== 1'b0 || bus.FETCH_PC !== 32'h0 || bus.FETCH_INST !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_fetch: got v=%b pc=%h inst=%h want 0/0/0",
                     bus.FETCH_VALID, bus.FETCH_PC, bus.FETCH_INST);
        end
`ifdef INST_FETCH_PERF_CNT_EN
        n_cmp++;
        if (PERF_WAIT_CNT !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_perf: got %0d want 0", PERF_WAIT_CNT);
        end
`endif
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_stream;
        apply_reset();
        lat_lo = 0; lat_hi = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (s_rden !== 1'b1 || s_raddr !== 32'(4 * k)) begin
                n_fail++;
                $display("FAIL stream_req[%0d]: got rden=%b addr=%h want 1/%h", k, s_rden, s_raddr, 32'(4 * k));
            end
            if (k >= 2) begin
                n_cmp++;
                if (s_fv !== 1'b1 || s_fpc !== 32'(4 * (k - 2))) begin
                    n_fail++;
                    $display("FAIL stream_fetch[%0d]: got v=%b pc=%h want 1/%h", k, s_fv, s_fpc, 32'(4 * (k - 2)));
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int acc0;
        int pop0;
        apply_reset();
        lat_lo = 0; lat_hi = 0;
        acc0 = n_acc;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            if (k >= 2) begin
                n_cmp++;
                if (s_fv !== 1'b1 || s_fpc !== 32'h0) begin
                    n_fail++;
                    $display("FAIL bp_head_hold[%0d]: got v=%b pc=%h want 1/00000000", k, s_fv, s_fpc);
                end
            end
        end
        n_cmp++;
        if (n_acc - acc0 != FIFO_DEPTH || s_rden !== 1'b0 || s_raddr !== 32'h10) begin
            n_fail++;
            $display("FAIL bp_full: got accepts=%0d rden=%b addr=%h want %0d/0/00000010",
                     n_acc - acc0, s_rden, s_raddr, FIFO_DEPTH);
        end
        pop0 = n_pop;
        for (int k = 0; k < 8; k++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (n_pop - pop0 < FIFO_DEPTH) begin
            n_fail++;
            $display("FAIL bp_drain: got pops=%0d want >=%0d", n_pop - pop0, FIFO_DEPTH);
        end
    endtask

    task automatic test_mem_wait;
        apply_reset();
        lat_lo = 0; lat_hi = 0;
        cycle(1'b1, 32'h20, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
            n_cmp++;
            if (s_rden !== 1'b1 || s_raddr !== 32'h20) begin
                n_fail++;
                $display("FAIL wait_hold[%0d]: got rden=%b addr=%h want 1/00000020", k, s_rden, s_raddr);
            end
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (s_acc !== 1'b1 || s_raddr !== 32'h20) begin
            n_fail++;
            $display("FAIL wait_release: got acc=%b addr=%h want 1/00000020", s_acc, s_raddr);
        end
`ifdef INST_FETCH_PERF_CNT_EN
        n_cmp++;
        if (PERF_WAIT_CNT !== 32'd5) begin
            n_fail++;
            $display("FAIL perf_wait_cnt: got %0d want 5", PERF_WAIT_CNT);
        end
`endif
        for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_flush;
        bit found = 1'b0;
        apply_reset();
        lat_lo = 1; lat_hi = 1;
        for (int k = 0; k < 100 && !found; k++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            if (s_acc && s_raddr == 32'h40) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL flush_setup: got no request at 00000040 want one within 100 cycles");
        end
        cycle(1'b1, 32'h1003, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (s_fv !== 1'b0 || s_rden !== 1'b1 || s_raddr !== 32'h1000) begin
            n_fail++;
            $display("FAIL flush_after: got v=%b rden=%b addr=%h want 0/1/00001000", s_fv, s_rden, s_raddr);
        end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            if (s_fv) begin
                found = 1'b1;
                n_cmp++;
                if (s_fpc !== 32'h1000) begin
                    n_fail++;
                    $display("FAIL flush_first_pc: got %h want 00001000", s_fpc);
                end
            end
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL flush_timeout: got no FETCH_VALID want one within 20 cycles");
        end
    endtask

    task automatic test_wrap;
        apply_reset();
        lat_lo = 0; lat_hi = 0;
        cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (s_acc !== 1'b1 || s_raddr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_first: got acc=%b addr=%h want 1/fffffffc", s_acc, s_raddr);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (s_acc !== 1'b1 || s_raddr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_next: got acc=%b addr=%h want 1/00000000", s_acc, s_raddr);
        end
        for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset;
        bit found = 1'b0;
        apply_reset();
        lat_lo = 2; lat_hi = 2;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            if (s_acc) found = 1'b1;
        end
        #2;
        RST = 1'b1;
        #1;
        n_cmp++;
        if (bus.FETCH_VALID !== 1'b0 || bus.INST_RDEN !== 1'b0 || bus.INST_RADDR !== START_ADDR) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b rden=%b addr=%h want 0/0/%h",
                     bus.FETCH_VALID, bus.INST_RDEN, bus.INST_RADDR, START_ADDR);
        end
        idle_inputs();
        pend    = 1'b0;
        exp_req = START_ADDR;
        exp_dec = START_ADDR;
        @(negedge CLK);
        RST = 1'b0;
        // Stale response right after release, nothing outstanding.
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (s_fv !== 1'b0 || s_raddr !== START_ADDR) begin
                n_fail++;
                $display("FAIL stale_resp[%0d]: got v=%b addr=%h want 0/%h", k, s_fv, s_raddr, START_ADDR);
            end
        end
        lat_lo = 0; lat_hi = 0;
        for (int k = 0; k < 6; k++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random;
        int pop0;
        apply_reset();
        lat_lo = 0; lat_hi = 2;
        pop0 = n_pop;
        for (int k = 0; k < 1500; k++) begin
            cycle(($urandom_range(31, 0) == 0),
                  $urandom,
                  ($urandom_range(3, 0) == 0),
                  ($urandom_range(2, 0) != 0),
                  ($urandom_range(7, 0) == 0));
        end
        n_cmp++;
        if (n_pop - pop0 < 100) begin
            n_fail++;
            $display("FAIL random_progress: got pops=%0d want >=100", n_pop - pop0);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_mem_wait();
        test_flush();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch_axi.md
Name: inst_fetch_axi

Overview:
- Instruction fetch front-end directly upstream of the AXI MMU.
- Generates sequential PCs and drives the MMU instruction read port (INST_RDEN/INST_RADDR).
- Honours MEM_WAIT, captures INST_RVALID/INST_RDATA into a small fetch queue, and presents {pc, inst} to decode over a valid/ready handshake.
- Handles redirects (branch/trap) by flushing the queue and discarding any in-flight response.

Parameters:
- FIFO_DEPTH, 4, fetch queue entries; power of two, minimum 2.
- START_ADDR, 32'h0000_0000, PC value after reset.

Ports:
- CLK  input  1  core clock
- RST  input  1  reset, asynchronous, active-high
- FLUSH  input  1  redirect request from execute/trap logic
- NEW_PC  input  32  redirect target; bits [1:0] are ignored and forced to 0
- MEM_WAIT  input  1  MMU stall; the request is not accepted while high
- INST_RDEN  output  1  fetch request to MMU
- INST_RADDR  output  32  fetch address (word aligned)
- INST_RVALID  input  1  fetch response valid
- INST_RDATA  input  32  fetch response data
- FETCH_VALID  output  1  queue head valid toward decode
- FETCH_PC  output  32  PC of queue head
- FETCH_INST  output  32  instruction of queue head
- FETCH_READY  input  1  decode accepts head
- PERF_WAIT_CNT  output  32  only with optional feature (see below)

Behaviour:
- Clock is CLK; reset is RST, asynchronous and active-high.
- Reset values:
  - pc = START_ADDR; INST_RDEN = 0; INST_RADDR = START_ADDR.
  - FETCH_VALID = 0; FETCH_PC = 0; FETCH_INST = 0.
  - Queue empty; outstanding = 0; discard = 0; PERF_WAIT_CNT = 0.
  - Reset mid-transfer drops all state; a response arriving after reset release with outstanding = 0 is ignored.
- Issue condition (combinational): INST_RDEN = !FLUSH && (occupancy + outstanding) < FIFO_DEPTH. INST_RADDR = pc.
- Acceptance = INST_RDEN && !MEM_WAIT. On acceptance:
  - pc <= pc + 4, 32-bit wrap (32'hFFFF_FFFC -> 0).
  - outstanding <= 1; req_pc <= pc.
- While MEM_WAIT = 1, INST_RDEN and INST_RADDR stay stable; pc does not advance.
- At most one request is outstanding. A new request may be accepted in the same cycle its predecessor's INST_RVALID arrives, giving a throughput of one per cycle on hits. Otherwise INST_RDEN is gated low while outstanding = 1 and no INST_RVALID is present.
- Response when INST_RVALID && outstanding:
  - If discard = 0, push {req_pc, INST_RDATA} into the queue.
  - If discard = 1, drop the response and clear discard.
  - outstanding clears unless a new acceptance occurs in the same cycle.
  - INST_RVALID with outstanding = 0 is ignored.
- Decode handshake:
  - Pop when FETCH_VALID && FETCH_READY.
  - FETCH_PC/FETCH_INST are held stable while FETCH_VALID && !FETCH_READY.
  - FETCH_VALID is driven from queue non-empty; queue-head data is presented with zero added latency.
  - A response received in cycle N is visible on FETCH_* in cycle N+1.
- Full/empty:
  - The credit check guarantees no overflow.
  - Push and pop in the same cycle are allowed at any occupancy, including full, when outstanding was counted.
  - A pop from an empty queue cannot occur.
- FLUSH (highest priority):
  - The queue is cleared next cycle; FETCH_VALID = 0 in the cycle after FLUSH.
  - pc <= {NEW_PC[31:2], 2'b00}.
  - INST_RDEN is forced 0 during the FLUSH cycle.
  - If outstanding = 1 and no INST_RVALID arrives in the FLUSH cycle, set discard = 1.
  - A response arriving in the FLUSH cycle is dropped.
  - A pop in the FLUSH cycle is still counted by decode; the flush source owns that ordering.
- Back-to-back FLUSH: the last NEW_PC wins; discard stays set until the single outstanding response returns.
- MMU interaction: new requests are not issued while discard = 1 and outstanding = 1, except in the cycle the discarded response arrives.

Optional Feature:
- Macro: INST_FETCH_PERF_CNT_EN.
- Defined:
  - PERF_WAIT_CNT port exists.
  - 32-bit saturating counter increments on every cycle with INST_RDEN && MEM_WAIT.
  - Reset to 0; unaffected by FLUSH; saturates at 32'hFFFF_FFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg:
  - fetch_entry_t {pc[31:0], inst[31:0]}.
  - INST_BYTES = 4.
  - PC_ALIGN_MASK = 32'hFFFF_FFFC.
  - Default START_ADDR.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, depth FIFO_DEPTH.
  - Ports: push, pop, clear, count, head.
  - Asynchronous active-high reset.
  - Pointer wrap uses log2(FIFO_DEPTH)+1-bit pointers.
- inst_fetch_axi holds pc, outstanding, discard, credit logic and the perf counter.

Test Plan:
- Reset release, MEM_WAIT = 0, 1-cycle INST_RVALID responder, FETCH_READY = 1 -> INST_RADDR 0x0, 0x4, 0x8 on consecutive cycles; FETCH_PC follows one cycle after each response; no gaps.
- FETCH_READY = 0, FIFO_DEPTH = 4 -> exactly 4 entries (PC 0x0–0xC) queued; INST_RDEN drops low; INST_RADDR holds 0x10; FETCH_PC stays 0x0.
- MEM_WAIT high for 5 cycles at PC 0x20 -> INST_RDEN = 1 and INST_RADDR = 0x20 stable; pc unchanged; with INST_FETCH_PERF_CNT_EN, PERF_WAIT_CNT = 5.
- FLUSH with NEW_PC = 0x1003 while request 0x40 is outstanding, response returned next cycle -> response dropped; queue empty; next INST_RADDR = 0x1000; first FETCH_PC = 0x1000.
- pc = 0xFFFF_FFFC accepted -> next INST_RADDR = 0x0000_0000.
- RST asserted asynchronously while outstanding = 1 with a stale INST_RVALID after release -> FETCH_VALID stays 0; INST_RADDR = START_ADDR.
